mp_add_seq: RTL and testbench

//  Multi-precision add sequencer that sits directly upstream of the N-bit ripple adder slice.
//  - Operands arrive as a stream of N-bit words, least-significant word (LSW) first.
//  - Each word pair goes through one combinational N-bit add (a + b + carry_reg).
//  - The carry is registered between words; the block emits a registered sum-word stream.
//  - Adds WORDS*N-bit operands on a narrow adder with valid/ready flow control on both sides.

---
 rtl/mp_add_seq.sv | 104 ++++++++++
 tb/tb_mp_add_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - multi-precision add sequencer: LSW-first word stream through an N-bit adder slice
// Optional SIGNED_OVF_EN adds the ovf port (signed overflow of the MSW add).
module mp_add_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cin,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum_out,
    output logic         out_last,
    output logic         cout,
    output logic         busy,
`ifdef SIGNED_OVF_EN
    output logic         ovf,
`endif
    output logic         done
);

    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          carry_reg;
    logic [N:0]    add_res;
    logic          in_fire;
    logic          out_fire;
    logic          last_in;
    logic          drain_done;

    assign add_res    = {1'b0, a_in} + {1'b0, b_in} + {{N{1'b0}}, carry_reg};
    assign in_ready   = (state == RUN) && (!out_valid || out_ready);
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign last_in    = in_fire && (cnt == LAST);
    // In DRAIN the output register can only hold the MSW sum word.
    assign drain_done = (state == DRAIN) && out_fire;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = RUN;
            RUN:     if (last_in)    state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            carry_reg <= 1'b0;
            sum_out   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            cout      <= 1'b0;
            done      <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            done <= drain_done;
            if (state == IDLE && start) begin
                carry_reg <= cin;
                cnt       <= '0;
`ifdef SIGNED_OVF_EN
                ovf       <= 1'b0;
`endif
            end
            if (in_fire) begin
                sum_out   <= add_res[N-1:0];
                carry_reg <= add_res[N];
                out_valid <= 1'b1;
                out_last  <= (cnt == LAST);
                if (cnt != LAST) cnt <= cnt + CW'(1);
`ifdef SIGNED_OVF_EN
                // Carry into the top bit is recovered as s ^ a ^ b at that bit.
                if (cnt == LAST)
                    ovf <= add_res[N] ^ (add_res[N-1] ^ a_in[N-1] ^ b_in[N-1]);
`endif
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
            if (drain_done) cout <= carry_reg;
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// tb/tb_mp_add_seq.sv - directed self-checking bench for mp_add_seq (N=8, WORDS=4)
module tb_mp_add_seq;

    logic       clk = 1'b0;
    logic       rst, start, cin, in_valid, out_ready;
    logic [7:0] a_in, b_in;
    logic       in_ready, out_valid, out_last, cout, busy, done;
    logic [7:0] sum_out;
`ifdef SIGNED_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    mp_add_seq #(.N(8), .WORDS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .cin(cin),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out),
        .out_last(out_last), .cout(cout), .busy(busy),
`ifdef SIGNED_OVF_EN
        .ovf(ovf),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation; out_ready is dropped for stall_len cycles from stall_from.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                         input int stall_from, input int stall_len, input bit poke_start,
                         output logic [31:0] sum, output int nw, output int last_cnt,
                         output int last_pos, output int done_cyc);
        int wi;
        int idx;
        logic [7:0] held;
        sum = '0; nw = 0; last_cnt = 0; last_pos = -1; done_cyc = -1; wi = 0; held = '0;
        @(negedge clk);
        start = 1'b1; cin = ci; in_valid = 1'b0; out_ready = 1'b1;
        #1 chk("in_ready_start_cycle", in_ready, 0);
        for (int cyc = 0; cyc < 40 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start     = poke_start && (cyc == 1);
            cin       = start;
            idx       = (wi < 4) ? wi : 0;
            in_valid  = (wi < 4);
            a_in      = a[8*idx +: 8];
            b_in      = b[8*idx +: 8];
            out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
            #1;
            if (!out_ready && out_valid) begin
                chk("stall_in_ready", in_ready, 0);
                if (cyc == stall_from) held = sum_out;
                else chk("stall_sum_held", sum_out, held);
            end
            if (done) done_cyc = cyc;
            if (out_valid && out_ready) begin
                if (nw < 4) sum[8*nw +: 8] = sum_out;
                if (out_last) begin
                    last_cnt++;
                    last_pos = nw;
                end
                nw++;
            end
            if (in_valid && in_ready) wi++;
        end
        start = 1'b0; cin = 1'b0; in_valid = 1'b0;
        if (done_cyc < 0) chk("done_timeout", 1, 0);
        @(negedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    logic [31:0] s;
    int nw, lc, lp, dc;

    initial begin
        rst = 1'b1; start = 1'b0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_in = '0; b_in = '0;
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_cout", cout, 0);
        chk("rst_sum_out", sum_out, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-stream after two accepted words
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; a_in = 8'h01; b_in = 8'h01;
        @(negedge clk);
        @(negedge clk);
        #1 chk("mid_busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        do_op(32'h00000001, 32'h00000001, 1'b0, 100, 0, 1'b0, s, nw, lc, lp, dc);
        chk("after_rst_sum", s, 32'h00000002);
        chk("after_rst_cout", cout, 0);
        chk("after_rst_words", nw, 4);

        // Carry chain
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 100, 0, 1'b0, s, nw, lc, lp, dc);
        chk("chain_sum", s, 32'h00000000);
        chk("chain_cout", cout, 1);
        chk("chain_last_pos", lp, 3);
        chk("chain_last_cnt", lc, 1);
        chk("chain_done_cycle", dc, 5);
        repeat (3) @(negedge clk);
        #1 chk("chain_cout_held", cout, 1);

        // Carry in
        do_op(32'h80001234, 32'h7FFFEDCC, 1'b1, 100, 0, 1'b0, s, nw, lc, lp, dc);
        chk("cin_sum", s, 32'h00000001);
        chk("cin_cout", cout, 1);

        // Backpressure
        do_op(32'h04030201, 32'h10101010, 1'b0, 1, 3, 1'b0, s, nw, lc, lp, dc);
        chk("bp_sum", s, 32'h14131211);
        chk("bp_words", nw, 4);
        chk("bp_cout", cout, 0);
        chk("bp_done_cycle", dc, 8);

        // start while busy is ignored
        do_op(32'h11111111, 32'h22222222, 1'b0, 100, 0, 1'b1, s, nw, lc, lp, dc);
        chk("ign_start_sum", s, 32'h33333333);
        chk("ign_start_cout", cout, 0);
        chk("ign_start_words", nw, 4);

`ifdef SIGNED_OVF_EN
        do_op(32'h7F000000, 32'h01000000, 1'b0, 100, 0, 1'b0, s, nw, lc, lp, dc);
        chk("ovf_pos_sum", s, 32'h80000000);
        chk("ovf_pos_ovf", ovf, 1);
        chk("ovf_pos_cout", cout, 0);
        do_op(32'hFF000000, 32'h01000000, 1'b0, 100, 0, 1'b0, s, nw, lc, lp, dc);
        chk("ovf_neg_sum", s, 32'h00000000);
        chk("ovf_neg_ovf", ovf, 0);
        chk("ovf_neg_cout", cout, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
